// File: rtl/pu_i2c_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pu_i2c_regfile_slave
// Purpose  : 7-bit-addressed I2C target with a pointer-addressed 8-bit
//            register file, auto-increment and a local write port.
// Revision : 1.0 - initial release
// ============================================================================
module pu_i2c_regfile_slave #(
    parameter logic [6:0] ADDRES_DEVICE = 7'h47,
    parameter int         REG_COUNT     = 4,
    parameter int         PW            = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl,
    inout  wire                    sda,
    output logic [8*REG_COUNT-1:0] reg_flat,
    input  logic                   wr,
    input  logic [PW-1:0]          wr_addr,
    input  logic [7:0]             wr_data,
    output logic                   i2c_wr,
    output logic [PW-1:0]          i2c_wr_addr,
    output logic                   busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8,
        ST_WAIT      = 4'd9
    } state_t;

    localparam logic [PW-1:0] c_ptr_one = PW'(1);

    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;
    state_t        r_state, w_state_nxt;
    logic [2:0]    r_bit_cnt, w_bit_nxt;
    logic [6:0]    r_rx, w_rx_nxt;
    logic [6:0]    r_tx, w_tx_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic          r_rw, w_rw_nxt;
    logic          r_ack_on, w_ack_on_nxt;
    logic          r_sda_low, w_sda_low_nxt;
    logic          r_i2c_wr;
    logic [PW-1:0] r_i2c_wr_addr;
    logic          r_busy;
    logic [7:0]    r_regs [REG_COUNT];
    logic          w_bus_wr;
    logic [7:0]    w_rx_byte;
    logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_pull;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_rx_byte  = {r_rx, r_sda_s2};

    // START/STOP mask the registered drive so the bus is let go in the detect cycle
    assign w_sda_pull = r_sda_low & ~w_start & ~w_stop;
    assign sda        = w_sda_pull ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx          <= 7'd0;
            r_tx          <= 7'd0;
            r_ptr         <= '0;
            r_rw          <= 1'b0;
            r_ack_on      <= 1'b0;
            r_sda_low     <= 1'b0;
            r_i2c_wr      <= 1'b0;
            r_i2c_wr_addr <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_rx          <= w_rx_nxt;
            r_tx          <= w_tx_nxt;
            r_ptr         <= w_ptr_nxt;
            r_rw          <= w_rw_nxt;
            r_ack_on      <= w_ack_on_nxt;
            r_sda_low     <= w_sda_low_nxt;
            r_i2c_wr      <= w_bus_wr;
            r_i2c_wr_addr <= w_bus_wr ? r_ptr : r_i2c_wr_addr;
            // busy only survives ADDR when it was already set by an earlier match
            r_busy        <= (r_state != ST_IDLE) && (r_state != ST_WAIT) &&
                             ((r_state != ST_ADDR) || r_busy);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_nxt     = r_bit_cnt;
        w_rx_nxt      = r_rx;
        w_tx_nxt      = r_tx;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_ack_on_nxt  = r_ack_on;
        w_sda_low_nxt = r_sda_low;
        w_bus_wr      = 1'b0;
        if (w_stop || w_start) begin
            w_state_nxt   = w_stop ? ST_IDLE : ST_ADDR;
            w_bit_nxt     = 3'd0;
            w_ack_on_nxt  = 1'b0;
            w_sda_low_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_rx_nxt  = w_rx_byte[6:0];
                        w_bit_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == ST_ADDR) begin
                                w_rw_nxt    = w_rx_byte[0];
                                w_state_nxt = (w_rx_byte[7:1] == ADDRES_DEVICE) ? ST_ADDR_ACK : ST_IDLE;
                            end else if (r_state == ST_PTR) begin
                                w_ptr_nxt   = w_rx_byte[PW-1:0];
                                w_state_nxt = ST_PTR_ACK;
                            end else begin
                                w_bus_wr    = 1'b1;
                                w_ptr_nxt   = r_ptr + c_ptr_one;
                                w_state_nxt = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // first SCL fall starts the ACK slot, the second ends it
                    if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            w_ack_on_nxt  = 1'b1;
                            w_sda_low_nxt = 1'b1;
                        end else begin
                            w_ack_on_nxt  = 1'b0;
                            w_sda_low_nxt = 1'b0;
                            if (r_state == ST_ADDR_ACK && r_rw) begin
                                w_state_nxt   = ST_RDATA;
                                w_tx_nxt      = r_regs[r_ptr][6:0];
                                w_sda_low_nxt = ~r_regs[r_ptr][7];
                            end else if (r_state == ST_ADDR_ACK) begin
                                w_state_nxt = ST_PTR;
                            end else begin
                                w_state_nxt = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            w_state_nxt   = ST_RACK;
                            w_sda_low_nxt = 1'b0;
                            w_ptr_nxt     = r_ptr + c_ptr_one;
                        end else begin
                            w_tx_nxt      = {r_tx[5:0], 1'b0};
                            w_sda_low_nxt = ~r_tx[6];
                        end
                    end
                end
                ST_RACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_s2) w_state_nxt = ST_WAIT;
                        else          w_ack_on_nxt = 1'b1;
                    end else if (w_scl_fall && r_ack_on) begin
                        w_ack_on_nxt  = 1'b0;
                        w_state_nxt   = ST_RDATA;
                        w_tx_nxt      = r_regs[r_ptr][6:0];
                        w_sda_low_nxt = ~r_regs[r_ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    // local write is applied last so it wins a same-cycle collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < REG_COUNT; k++) r_regs[k] <= 8'd0;
        end else begin
            if (w_bus_wr) r_regs[r_ptr]   <= w_rx_byte;
            if (wr)       r_regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_flat
        assign reg_flat[8*k +: 8] = r_regs[k];
    end

    assign i2c_wr      = r_i2c_wr;
    assign i2c_wr_addr = r_i2c_wr_addr;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pu_i2c_regfile_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pu_i2c_regfile_slave
// Purpose  : Bit-banged I2C initiator with scoreboarded commits and reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_i2c_regfile_slave;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       m_scl     = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       wr        = 1'b0;
    logic [1:0] wr_addr   = 2'd0;
    logic [7:0] wr_data   = 8'd0;
    wire        sda;
    wire [31:0] reg_flat;
    wire        i2c_wr;
    wire [1:0]  i2c_wr_addr;
    wire        busy;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    pu_i2c_regfile_slave #(.ADDRES_DEVICE(7'h47), .REG_COUNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .scl         (m_scl),
        .sda         (sda),
        .reg_flat    (reg_flat),
        .wr          (wr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .i2c_wr      (i2c_wr),
        .i2c_wr_addr (i2c_wr_addr),
        .busy        (busy)
    );

    int         total    = 0;
    int         bad      = 0;
    int         cnt_pull = 0;
    int         cnt_busy = 0;
    logic [9:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] rd_byte;
    event       rd_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // observers of DUT-only bus activity
    always @(posedge clk) begin
        if (sda === 1'b0 && !m_sda_low) cnt_pull = cnt_pull + 1;
        if (busy) cnt_busy = cnt_busy + 1;
    end

    always @(negedge clk) begin
        if (i2c_wr) begin
            if (exp_wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL i2c_wr_unexpected: got pulse addr %0d expected no pulse", i2c_wr_addr);
            end else begin
                logic [9:0] e;
                int         idx;
                e   = exp_wr_q.pop_front();
                idx = int'(e[9:8]);
                check("i2c_wr_addr", {30'd0, i2c_wr_addr}, {30'd0, e[9:8]});
                check("i2c_wr_data", {24'd0, reg_flat[8*idx +: 8]}, {24'd0, e[7:0]});
            end
        end
    end

    initial begin
        forever begin
            @(rd_ev);
            if (exp_rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got byte %0h expected none", rd_byte);
            end else begin
                check("rd_byte", {24'd0, rd_byte}, {24'd0, exp_rd_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, input logic collide, output logic r);
        wait_clk(4);
        m_sda_low = ~b;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(2);
        if (collide) wr = 1'b1;
        wait_clk(1);
        wr = 1'b0;
        wait_clk(1);
        r = (sda !== 1'b0);
        wait_clk(4);
        m_scl = 1'b0;
    endtask

    task automatic start_cond;
        wait_clk(4);
        m_sda_low = 1'b0;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(6);
        m_sda_low = 1'b1;
        wait_clk(6);
        m_scl = 1'b0;
    endtask

    task automatic stop_cond;
        wait_clk(4);
        m_sda_low = 1'b1;
        wait_clk(4);
        m_scl = 1'b1;
        wait_clk(6);
        m_sda_low = 1'b0;
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] v, input logic collide, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], collide && (i == 0), r);
        bus_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack);
        logic [7:0] v;
        logic       r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            v[i] = r;
        end
        bus_bit(~ack, 1'b0, r);
        rd_byte = v;
        -> rd_ev;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic ack;
        int   p0, b0;

        wait_clk(5);
        check("reset_reg_flat", reg_flat, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_i2c_wr", {31'd0, i2c_wr}, 32'd0);
        check("reset_i2c_wr_addr", {30'd0, i2c_wr_addr}, 32'd0);
        check("reset_sda_low", {31'd0, sda === 1'b0}, 32'd0);
        rst = 1'b1;
        wait_clk(5);

        // plain write with auto-increment
        exp_wr_q.push_back({2'd1, 8'h5A});
        exp_wr_q.push_back({2'd2, 8'hC3});
        start_cond;
        write_byte(8'h8E, 1'b0, ack); check("t1_addr_ack", {31'd0, ack}, 32'd1);
        check("t1_busy_mid", {31'd0, busy}, 32'd1);
        write_byte(8'h01, 1'b0, ack); check("t1_ptr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h5A, 1'b0, ack); check("t1_d0_ack", {31'd0, ack}, 32'd1);
        write_byte(8'hC3, 1'b0, ack); check("t1_d1_ack", {31'd0, ack}, 32'd1);
        stop_cond;
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_reg_flat", reg_flat, 32'h00C3_5A00);

        // combined read via repeated START
        exp_rd_q.push_back(8'h5A);
        exp_rd_q.push_back(8'hC3);
        start_cond;
        write_byte(8'h8E, 1'b0, ack); check("t2_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h01, 1'b0, ack); check("t2_ptr_ack", {31'd0, ack}, 32'd1);
        start_cond;
        write_byte(8'h8F, 1'b0, ack); check("t2_raddr_ack", {31'd0, ack}, 32'd1);
        read_byte(1'b1);
        read_byte(1'b0);
        wait_clk(4);
        check("t2_sda_after_nack", {31'd0, sda === 1'b0}, 32'd0);
        check("t2_busy_in_wait", {31'd0, busy}, 32'd0);
        stop_cond;

        // foreign address
        p0 = cnt_pull;
        b0 = cnt_busy;
        start_cond;
        write_byte(8'h90, 1'b0, ack); check("t3_no_ack", {31'd0, ack}, 32'd0);
        wait_clk(8);
        stop_cond;
        check("t3_no_pull", cnt_pull - p0, 32'd0);
        check("t3_no_busy", cnt_busy - b0, 32'd0);
        check("t3_reg_flat", reg_flat, 32'h00C3_5A00);

        // pointer wrap on write, pointer masking on read
        exp_wr_q.push_back({2'd3, 8'h11});
        exp_wr_q.push_back({2'd0, 8'h22});
        start_cond;
        write_byte(8'h8E, 1'b0, ack);
        write_byte(8'h03, 1'b0, ack);
        write_byte(8'h11, 1'b0, ack);
        write_byte(8'h22, 1'b0, ack); check("t4_d1_ack", {31'd0, ack}, 32'd1);
        stop_cond;
        check("t4_reg_flat", reg_flat, 32'h11C3_5A22);
        exp_rd_q.push_back(8'h5A);
        start_cond;
        write_byte(8'h8E, 1'b0, ack);
        write_byte(8'hFD, 1'b0, ack); check("t4_ptr_fd_ack", {31'd0, ack}, 32'd1);
        start_cond;
        write_byte(8'h8F, 1'b0, ack);
        read_byte(1'b0);
        stop_cond;

        // local write colliding with a bus commit to the same register
        wr_addr = 2'd2;
        wr_data = 8'h77;
        exp_wr_q.push_back({2'd2, 8'h77});
        start_cond;
        write_byte(8'h8E, 1'b0, ack);
        write_byte(8'h02, 1'b0, ack);
        write_byte(8'hC3, 1'b1, ack);
        stop_cond;
        check("t5_reg_flat", reg_flat, 32'h1177_5A22);

        // reset while the target drives a 0 data bit (reg0 = 0x22, MSB 0)
        start_cond;
        write_byte(8'h8E, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        start_cond;
        write_byte(8'h8F, 1'b0, ack); check("t6_raddr_ack", {31'd0, ack}, 32'd1);
        wait_clk(4);
        check("t6_drives_zero", {31'd0, sda === 1'b0}, 32'd1);
        rst = 1'b0;
        #1;
        check("t6_sda_released", {31'd0, sda === 1'b0}, 32'd0);
        check("t6_reg_flat_reset", reg_flat, 32'h0);
        check("t6_busy_reset", {31'd0, busy}, 32'd0);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        stop_cond;
        exp_wr_q.push_back({2'd2, 8'hA5});
        start_cond;
        write_byte(8'h8E, 1'b0, ack); check("t6_post_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h02, 1'b0, ack);
        write_byte(8'hA5, 1'b0, ack); check("t6_post_data_ack", {31'd0, ack}, 32'd1);
        stop_cond;
        check("t6_post_reg_flat", reg_flat, 32'h00A5_0000);

        wait_clk(10);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        check("rd_queue_drained", exp_rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pu_i2c_regfile_slave.md
# pu_i2c_regfile_slave

I2C target (responder) exposing a small 8-bit register file to an external I2C initiator, with pointer addressing and auto-increment. It answers the same bus protocol that pu_i2c_master_driver initiates. It sits at the chip edge on the scl/sda pair and presents the register contents plus a local update port to the surrounding processor unit. It implements 7-bit addressing, no clock stretching and no 10-bit or general-call support.

## Interface
- ADDRES_DEVICE, 7'h47: 7-bit bus address answered.
- REG_COUNT, 4: number of 8-bit registers; must be a power of two, at least 2. PW = $clog2(REG_COUNT).
- clk  input  1  system clock; must be at least 8× SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock, sampled only.
- sda  inout  1  open-drain: driven 0 when pulling low, otherwise 1'bz.
- reg_flat  output  8*REG_COUNT  register contents; reg k occupies bits [8k+7:8k].
- wr  input  1  local write strobe.
- wr_addr  input  PW  local write index.
- wr_data  input  8  local write data.
- i2c_wr  output  1  one-cycle pulse when a bus write commits a register.
- i2c_wr_addr  output  PW  index committed with i2c_wr.
- busy  output  1  high from an address-matched START until STOP.

## Operation
- Input conditioning:
  - scl and sda pass through 2-FF synchronizers, then a registered previous-value stage for edge detection.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled on the detected SCL rise.
  - The drive value changes on the detected SCL fall.
  - Bits are MSB first; the bit counter is 3 bits.
- State machine:
  - IDLE: sda released. START → ADDR.
  - ADDR: shift in 8 bits.
    - Address match with R/W=0 → ADDR_ACK, then PTR.
    - Address match with R/W=1 → ADDR_ACK, then RDATA.
    - Mismatch → IDLE without ACK.
  - ADDR_ACK / PTR_ACK / WDATA_ACK: pull sda low for the 9th SCL period, from the SCL fall after bit 8 to the following SCL fall.
  - PTR: shift 8 bits; pointer = low PW bits of the byte; → PTR_ACK → WDATA.
  - WDATA: shift 8 bits into a shift register.
    - Write reg[pointer] and pulse i2c_wr with i2c_wr_addr = pointer at the 8th sampling edge.
    - Then pointer = pointer+1 mod REG_COUNT → WDATA_ACK → WDATA.
  - RDATA:
    - Load reg[pointer] into the transmit shift register at entry.
    - Drive sda low for each 0 bit and release it for each 1 bit.
    - After 8 bits → RACK, release sda, pointer+1 mod REG_COUNT.
  - RACK: sample the master's bit. 0 (ACK) → RDATA. 1 (NACK) → WAIT.
  - WAIT: sda released; wait for START or STOP.
- Priority rules:
  - START in any state → ADDR (repeated start). The pointer is kept, so a read continues from the last pointer.
  - STOP in any state → IDLE.
  - START/STOP take priority over bit sampling in the same cycle.
- Local port:
  - wr writes reg[wr_addr] = wr_data.
  - If wr and a bus write target the same register in the same cycle, the local write wins. i2c_wr still pulses.
  - A local write to the register currently being transmitted does not alter the byte already loaded.
- busy = state not in {IDLE, WAIT}, masked to matched transactions.

## Timing
- Reset (rst=0, asynchronous):
  - sda released (z) immediately.
  - State IDLE, all registers 0, pointer 0, bit counter 0.
  - i2c_wr 0, i2c_wr_addr 0, busy 0.
  - Synchronizers preset to 1.
- Reset asserted mid-transfer: the bus is released in the same cycle. After release, the block ignores traffic until the next START.
- Pin-to-detect latency: 3 clk (2 sync + 1 edge).
- sda drive update: ≤4 clk after the SCL pin falls; requires SCL low time ≥ 5 clk.
- reg_flat updates 1 clk after the commit edge.
- i2c_wr is exactly 1 clk wide.
- busy rises 1 clk after ADDR_ACK is entered and falls 1 clk after STOP is detected.
- Pointer wrap: REG_COUNT-1 → 0 for both reads and writes.
- A START detected during an ACK slot releases sda in the same cycle.

## Test plan
- Write: START, 0x8E ACK, ptr 0x01 ACK, 0x5A ACK, 0xC3 ACK, STOP → reg1=0x5A, reg2=0xC3; two i2c_wr pulses with addr 1 then 2; busy low after STOP.
- Combined read: START, 0x8E, ptr 0x01, repeated START, 0x8F, read with master ACK then NACK, STOP → bytes 0x5A then 0xC3 on sda; sda released after NACK.
- Wrong address: START, 0x90, 8 more clocks, STOP → sda never low, busy stays 0, registers unchanged.
- Wrap: ptr 0x03, data 0x11 0x22 → reg3=0x11, reg0=0x22; pointer byte 0xFD behaves as ptr 1.
- Collision: local wr addr 2 data 0x77 in the same cycle as a bus commit of 0xC3 to reg2 → reg2=0x77, i2c_wr pulses with addr 2.
- Reset mid-read: assert rst while a 0 bit is driven → sda z in the same cycle, registers 0; next full write transaction succeeds.
